// File: rtl/serial_addsub20_ctrl.sv
// Multi-cycle WIDTH-bit adder/subtractor: one 5-bit carry-lookahead slice reused LSB-first.
// Optional build macro ADDSUB_SAT_EN clamps the result on signed overflow.

module bit5_cla_adder (
  input  logic [4:0] a,
  input  logic [4:0] b,
  input  logic       cin,
  output logic [4:0] sum,
  output logic       cout
);

  logic [4:0] g;
  logic [4:0] p;
  logic [5:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Every carry is flattened from cin and the generate/propagate terms; none waits on a lower carry.
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);
  assign c[5] = g[4] | (p[4] & g[3]) | (p[4] & p[3] & g[2]) | (p[4] & p[3] & p[2] & g[1])
              | (p[4] & p[3] & p[2] & p[1] & g[0]) | (p[4] & p[3] & p[2] & p[1] & p[0] & cin);

  assign sum  = p ^ c[4:0];
  assign cout = c[5];

endmodule

module serial_addsub20_ctrl #(
  parameter int WIDTH = 20,
  parameter int SLICE = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [IW-1:0]    idx;
  logic             carry;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;

  logic [SLICE-1:0] slice_a;
  logic [SLICE-1:0] slice_b;
  logic [SLICE-1:0] slice_sum;
  logic             slice_cout;
  logic             last_slice;
  logic             ovf_next;
  logic             saturate;

  assign slice_a = opa[idx*SLICE +: SLICE];
  assign slice_b = opb[idx*SLICE +: SLICE];

  bit5_cla_adder u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  assign last_slice = (idx == IW'(NSLICE - 1));

  // opb is already inverted for subtraction, so the add-form overflow rule covers both modes.
  assign ovf_next = ~(opa[WIDTH-1] ^ opb[WIDTH-1]) & (slice_sum[SLICE-1] ^ opa[WIDTH-1]);

`ifdef ADDSUB_SAT_EN
  assign saturate = ovf_next;
`else
  assign saturate = 1'b0;
`endif

  // NOTE: all state here uses non-blocking assignments so every register sees pre-edge values;
  // a later assignment in the same edge (saturation) cleanly overrides the slice write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      carry    <= 1'b0;
      opa      <= '0;
      opb      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            opa      <= a;
            opb      <= b ^ {WIDTH{sub}};
            carry    <= sub;
            idx      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
            busy     <= 1'b1;
            state    <= RUN;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end

        RUN: begin
          result[idx*SLICE +: SLICE] <= slice_sum;
          carry <= slice_cout;
          idx   <= idx + 1'b1;
          if (last_slice) begin
            state    <= DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            cout     <= slice_cout;
            overflow <= ovf_next;
            if (saturate) result <= opa[WIDTH-1] ? SAT_MIN : SAT_MAX;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub20_ctrl.sv
// Self-checking bench for serial_addsub20_ctrl: arithmetic reference model compared every cycle,
// plus directed vectors with hand-computed expectations (latency, ripple, borrow, overflow, handshake, reset).

module tb_serial_addsub20_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        sub = 1'b0;
  logic [19:0] a = '0;
  logic [19:0] b = '0;
  logic        busy;
  logic        done;
  logic [19:0] result;
  logic        cout;
  logic        overflow;

  int tests = 0;
  int fails = 0;

`ifdef ADDSUB_SAT_EN
  localparam logic [19:0] EXP_7FFFF_P1 = 20'h7FFFF;
  localparam logic [19:0] EXP_80000_M1 = 20'h80000;
  localparam logic [19:0] EXP_80000_X2 = 20'h80000;
`else
  localparam logic [19:0] EXP_7FFFF_P1 = 20'h80000;
  localparam logic [19:0] EXP_80000_M1 = 20'h7FFFF;
  localparam logic [19:0] EXP_80000_X2 = 20'h00000;
`endif

  always #5 clk = ~clk;

  serial_addsub20_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .sub      (sub),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .cout     (cout),
    .overflow (overflow)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic: plain integer add/subtract, range test for signed overflow.
  task automatic model_op(input logic [19:0] x, input logic [19:0] y, input logic s,
                          output logic [19:0] r, output logic c, output logic v);
    int sx, sy, sr;
    logic [20:0] u;
    sx = $signed(x);
    sy = $signed(y);
    if (s) begin
      u  = {1'b0, x} - {1'b0, y};
      c  = (x >= y);
      sr = sx - sy;
    end else begin
      u  = {1'b0, x} + {1'b0, y};
      c  = u[20];
      sr = sx + sy;
    end
    r = u[19:0];
    v = (sr > 524287) || (sr < -524288);
`ifdef ADDSUB_SAT_EN
    if (v) r = (sx < 0) ? 20'h80000 : 20'h7FFFF;
`endif
  endtask

  // Model: an accepted request completes four cycles later; requests while busy are dropped.
  int          m_cnt = 0;
  logic        m_busy = 1'b0, m_done = 1'b0, m_cout = 1'b0, m_ovf = 1'b0;
  logic [19:0] m_res = '0, p_res = '0;
  logic        p_cout = 1'b0, p_ovf = 1'b0;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_cnt = 0; m_busy = 0; m_done = 0; m_res = '0; m_cout = 0; m_ovf = 0;
    end else begin
      m_done = 0;
      if (m_busy) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_busy = 0; m_done = 1; m_res = p_res; m_cout = p_cout; m_ovf = p_ovf;
        end
      end else if (start) begin
        model_op(a, b, sub, p_res, p_cout, p_ovf);
        m_cnt = 4; m_busy = 1; m_cout = 0; m_ovf = 0;
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    check("cyc busy", 32'(busy), 32'(m_busy));
    check("cyc done", 32'(done), 32'(m_done));
    if (!m_busy) begin
      check("cyc result",   32'(result),   32'(m_res));
      check("cyc cout",     32'(cout),     32'(m_cout));
      check("cyc overflow", 32'(overflow), 32'(m_ovf));
    end
  end

  // Issues one request, scrambles inputs while busy, and returns on the cycle done is seen.
  task automatic run_op(input string name, input logic [19:0] x, input logic [19:0] y, input logic s,
                        input logic [19:0] er, input logic ec, input logic ev);
    int n, bcnt;
    bit seen;
    @(negedge clk);
    a = x; b = y; sub = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = 20'($urandom); b = 20'($urandom); sub = 1'($urandom);
    n = 1; bcnt = 0; seen = 0;
    while (n <= 12 && !seen) begin
      if (done) seen = 1;
      else begin
        if (busy) bcnt++;
        @(negedge clk);
        n++;
      end
    end
    check({name, " done seen"}, 32'(seen), 32'd1);
    if (seen) begin
      check({name, " latency"},  n, 5);
      check({name, " busy len"}, bcnt, 4);
      check({name, " result"},   32'(result),   32'(er));
      check({name, " cout"},     32'(cout),     32'(ec));
      check({name, " overflow"}, 32'(overflow), 32'(ev));
    end
  endtask

  initial begin
    int donec;
    bit seen2;
    int n2;

    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst busy",   32'(busy),     32'd0);
    check("rst done",   32'(done),     32'd0);
    check("rst result", 32'(result),   32'd0);
    check("rst cout",   32'(cout),     32'd0);
    check("rst ovf",    32'(overflow), 32'd0);

    run_op("add basic",  20'h12345, 20'h54321, 1'b0, 20'h66666, 1'b0, 1'b0);
    run_op("sub borrow", 20'h00005, 20'h00007, 1'b1, 20'hFFFFE, 1'b0, 1'b0);
    run_op("sub pos",    20'h00007, 20'h00005, 1'b1, 20'h00002, 1'b1, 1'b0);
    run_op("ripple",     20'hFFFFF, 20'h00001, 1'b0, 20'h00000, 1'b1, 1'b0);
    run_op("ovf add",    20'h7FFFF, 20'h00001, 1'b0, EXP_7FFFF_P1, 1'b0, 1'b1);
    run_op("ovf sub",    20'h80000, 20'h00001, 1'b1, EXP_80000_M1, 1'b1, 1'b1);
    run_op("ovf negneg", 20'h80000, 20'h80000, 1'b0, EXP_80000_X2, 1'b1, 1'b1);
    run_op("zero minus", 20'h00000, 20'h00000, 1'b1, 20'h00000, 1'b1, 1'b0);

    // Starts during RUN are ignored; a start held in DONE is taken immediately.
    @(negedge clk);
    a = 20'h11111; b = 20'h22222; sub = 1'b0; start = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      check("hs busy run", 32'(busy), 32'd1);
      a = 20'hFFFFF; b = 20'hFFFFF; sub = 1'b1; start = 1'b1;
    end
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("hs first done",   32'(done),   32'd1);
    check("hs first result", 32'(result), 32'h33333);
    a = 20'h00010; b = 20'h00003; sub = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("hs b2b busy", 32'(busy), 32'd1);
    check("hs b2b done", 32'(done), 32'd0);
    n2 = 1; seen2 = 0;
    while (n2 <= 12 && !seen2) begin
      if (done) seen2 = 1;
      else begin
        @(negedge clk);
        n2++;
      end
    end
    check("hs second seen", 32'(seen2), 32'd1);
    check("hs second gap", n2, 5);
    check("hs second result", 32'(result), 32'h0000D);
    check("hs second cout",   32'(cout),   32'd1);

    // Reset in the middle of an operation discards it.
    @(negedge clk);
    a = 20'h0AAAA; b = 20'h05555; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid rst busy",   32'(busy),     32'd0);
    check("mid rst done",   32'(done),     32'd0);
    check("mid rst result", 32'(result),   32'd0);
    check("mid rst cout",   32'(cout),     32'd0);
    check("mid rst ovf",    32'(overflow), 32'd0);
    donec = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) donec++;
    end
    check("mid rst no done", donec, 0);
    run_op("after rst", 20'h0AAAA, 20'h05555, 1'b0, 20'h0FFFF, 1'b0, 1'b0);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
